// File: rtl/seq_div_top.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow detection.
module seq_div_top #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    // Partial remainder is always below the divisor, so WIDTH bits hold it; the
    // extra bit only exists transiently in the shifted trial value.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             qbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        trial = {rem_q, lo_q[WIDTH-1]};
        qbit  = (trial >= {1'b0, dvs_q});
        // Only used when qbit is set, where the true difference fits WIDTH bits.
        diff  = trial[WIDTH-1:0] - dvs_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = dividend[2*WIDTH-1:WIDTH];
                    lo_d    = dividend[WIDTH-1:0];
                    dvs_d   = divisor;
                    cnt_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (dvs_q == '0) begin
                    dbz_d   = 1'b1;
                    ovf_d   = 1'b0;
                    quot_d  = '1;
                    rmd_d   = lo_q;
                    state_d = StDone;
                end else if (rem_q >= dvs_q) begin
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b1;
                    quot_d  = '1;
                    rmd_d   = '0;
                    state_d = StDone;
                end else begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                rem_d = qbit ? diff : trial[WIDTH-1:0];
                // Dividend bits shift out the top while quotient bits fill the bottom.
                lo_d  = {lo_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    quot_d  = lo_d;
                    rmd_d   = rem_d;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
